// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the RAM request/load path.
// Size encodings, response entry, store lane steering and load alignment/extension.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  function automatic logic req_err(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd3) | ((size == SZ_HALF) & off[0]) | ((size == SZ_WORD) & (off != 2'd0));
  endfunction

  function automatic logic [3:0] store_we(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] we;
    case (size)
      SZ_BYTE: we = 4'b0001 << off;
      SZ_HALF: we = off[1] ? 4'b1100 : 4'b0011;
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] store_din(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] din;
    case (size)
      SZ_BYTE: din = {4{wdata[7:0]}};
      SZ_HALF: din = {2{wdata[15:0]}};
      default: din = wdata;
    endcase
    return din;
  endfunction

  // Right-justifies the addressed lane, zero-filled above it.
  function automatic logic [31:0] lane_select(input logic [31:0] dout, input logic [1:0] size,
                                              input logic [1:0] off);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {24'd0, dout[{off, 3'b000} +: 8]};
      SZ_HALF: r = {16'd0, dout[{off[1], 4'b0000} +: 16]};
      default: r = dout;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sgn);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_rsp_fifo.sv
// Response buffer: DEPTH-entry synchronous FIFO with occupancy count.
// Push and pop may coincide; the head reads as zero while empty.
module rsp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  rsp_t          push_dat_i,
  input  logic          pop_i,
  output rsp_t          head_o,
  output logic          vld_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign vld_o   = (count_q != '0);
  assign do_pop  = pop_i & vld_o;
  assign count_o = count_q;
  assign head_o  = vld_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked until an entry is written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a single-port byte-enabled RAM: lane steering, one-cycle
// read absorption, load alignment/extension and a credit-limited in-order response buffer.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_dout
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
    logic       err;
  } s1_t;

  s1_t         s1_q, s1_d;
  logic [1:0]  off;
  logic        err, accept;
  logic [CW-1:0] fifo_count;
  logic [CW:0] credit_used;
  rsp_t        push_dat, head;

  assign off    = req_addr[1:0];
  assign err    = req_err(req_size, off);
  assign accept = req_valid & req_ready;

  // Stage 1 holds a credit too, so an in-flight read always finds a free FIFO slot.
  assign credit_used = {{CW{1'b0}}, s1_q.vld} + {1'b0, fifo_count};
  assign req_ready   = ~rst & (credit_used < DEPTH_L);

  assign ram_en   = accept & ~err;
  assign ram_addr = req_addr[AW+1:2];
  assign ram_din  = store_din(req_size, req_wdata);
  assign ram_we   = (ram_en & req_write) ? store_we(req_size, off) : 4'b0000;

  always_comb begin
    s1_d = '0;
    if (accept) begin
      s1_d.vld  = 1'b1;
      s1_d.wr   = req_write;
      s1_d.size = req_size;
      s1_d.sgn  = req_signed;
      s1_d.off  = off;
      s1_d.err  = err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  always_comb begin
    push_dat     = '0;
    push_dat.err = s1_q.err;
    if (!s1_q.wr && !s1_q.err)
      push_dat.rdata = extend(lane_select(ram_dout, s1_q.size, s1_q.off), s1_q.size, s1_q.sgn);
  end

  rsp_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (s1_q.vld),
    .push_dat_i(push_dat),
    .pop_i     (rsp_ready),
    .head_o    (head),
    .vld_o     (rsp_valid),
    .count_o   (fifo_count)
  );

  assign rsp_rdata = head.rdata;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded bench for mem_access_ctrl with a byte-array memory model and a behavioural RAM.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic          req_ready;
  logic [1:0]    req_size = 2'd0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [3:0]    ram_we;
  logic [31:0]   ram_dout = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Behavioural RAM: byte-enabled write, registered read; contents survive reset.
  logic [31:0] ram [0:(1<<AW)-1] = '{default: 32'd0};
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      if (ram_we == 4'b0000) ram_dout <= ram[ram_addr];
    end
  end

  // Reference memory as a flat byte array.
  logic [7:0] ref_mem [0:(1<<(AW+2))-1] = '{default: 8'd0};

  typedef struct {
    logic          w;
    logic [1:0]    sz;
    logic          sg;
    logic [AW+1:0] a;
    logic [31:0]   wd;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0, cyc = 0;
  bit   lat_exact = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit is_err(input logic [1:0] sz, input logic [AW+1:0] a);
    return (sz == 2'd3) || ((int'(a) % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [AW+1:0] a, input logic [1:0] sz,
                                             input logic sg);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic void model_store(input logic [AW+1:0] a, input logic [1:0] sz,
                                      input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
  endfunction

  function automatic req_t mk(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [AW+1:0] a, input logic [31:0] wd);
    req_t r;
    r.w = w; r.sz = sz; r.sg = sg; r.a = a; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.w  = 1'($urandom_range(0, 1));
    r.sg = 1'($urandom_range(0, 1));
    r.sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    r.a  = (AW+2)'($urandom_range(0, 63));
    if (r.sz != 2'd3 && $urandom_range(0, 4) != 0)
      r.a = r.a & ~((AW+2)'(nbytes(r.sz) - 1));
    r.wd = $urandom;
    return r;
  endfunction

  // Presents one request for one cycle; checks the RAM side and records the expected response.
  task automatic step(input req_t r, output bit acc);
    bit e;
    int n;
    logic [3:0]  we_e;
    logic [31:0] din_e;
    req_valid = 1'b1; req_write = r.w; req_size = r.sz; req_signed = r.sg;
    req_addr = r.a; req_wdata = r.wd;
    #1;
    acc = req_ready;
    e = is_err(r.sz, r.a);
    check("ram_en", 32'(ram_en), 32'(acc && !e));
    if (acc && !e) begin
      check("ram_addr", 32'(ram_addr), 32'(r.a >> 2));
      if (r.w) begin
        n = nbytes(r.sz);
        we_e = 4'(((1 << n) - 1) << r.a[1:0]);
        for (int i = 0; i < 4; i++) din_e[8*i +: 8] = r.wd[8*(i % n) +: 8];
        check("ram_we_store", 32'(ram_we), 32'(we_e));
        check("ram_din", ram_din, din_e);
        model_store(r.a, r.sz, r.wd);
      end else begin
        check("ram_we_load", 32'(ram_we), 32'd0);
      end
    end else begin
      check("ram_we_idle", 32'(ram_we), 32'd0);
    end
    if (acc)
      sb.push_back('{(e || r.w) ? 32'd0 : model_load(r.a, r.sz, r.sg), e, cyc, lat_exact});
    @(posedge clk); #1;
  endtask

  task automatic issue(input req_t r);
    bit acc;
    int tries;
    tries = 0;
    do begin
      step(r, acc);
      tries++;
    end while (!acc && tries < 100);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: request not accepted in %0d cycles, expected acceptance", tries);
    end else if (lat_exact) begin
      check("full_throughput", 32'(tries), 32'd1);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold-stability while stalled.
  exp_t        mon_x;
  bit          last_stall = 1'b0;
  logic [31:0] last_d = '0;
  logic        last_e = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      last_stall = 1'b0;
    end else if (rsp_valid) begin
      if (last_stall) begin
        check("hold_rdata", rsp_rdata, last_d);
        check("hold_err", 32'(rsp_err), 32'(last_e));
      end
      if (rsp_ready) begin
        last_stall = 1'b0;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
        end else begin
          mon_x = sb.pop_front();
          check("rsp_rdata", rsp_rdata, mon_x.rdata);
          check("rsp_err", 32'(rsp_err), 32'(mon_x.err));
          if (mon_x.exact) check("rsp_latency", 32'(cyc), 32'(mon_x.acc + 2));
        end
      end else begin
        last_stall = 1'b1;
        last_d = rsp_rdata;
        last_e = rsp_err;
      end
    end else begin
      last_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n_acc, k, idx;
    req_t r;

    // A store is held on the bus through reset and must not reach the RAM.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_addr = 'h40; req_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("ready_after_release", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Directed sequences with rsp_ready held high: exact c+2 latency applies.
    rsp_ready = 1'b1;
    lat_exact = 1'b1;
    issue(mk(1'b1, SZ_WORD, 1'b0, 'h010, 32'hDEAD_BEEF));
    issue(mk(1'b0, SZ_WORD, 1'b0, 'h010, 32'h0));
    issue(mk(1'b1, SZ_BYTE, 1'b0, 'h013, 32'h0000_007F));
    issue(mk(1'b0, SZ_BYTE, 1'b1, 'h013, 32'h0));
    issue(mk(1'b1, SZ_BYTE, 1'b0, 'h013, 32'h0000_0080));
    issue(mk(1'b0, SZ_BYTE, 1'b1, 'h013, 32'h0));
    issue(mk(1'b1, SZ_HALF, 1'b0, 'h022, 32'h0000_A55A));
    issue(mk(1'b0, SZ_HALF, 1'b0, 'h022, 32'h0));
    issue(mk(1'b0, SZ_HALF, 1'b1, 'h022, 32'h0));
    issue(mk(1'b0, SZ_WORD, 1'b0, 'h005, 32'h0));
    issue(mk(1'b0, SZ_HALF, 1'b0, 'h003, 32'h0));
    issue(mk(1'b0, 2'd3,    1'b0, 'h000, 32'h0));
    drain();

    // Random back-to-back traffic at full throughput.
    for (int i = 0; i < 200; i++) issue(rand_req());
    drain();
    lat_exact = 1'b0;

    // Stall: eight back-to-back loads against a blocked response port.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(mk(1'b0, SZ_WORD, 1'b0, (AW+2)'(4 * n_acc), 32'h0), acc);
      if (acc) n_acc++;
    end
    check("stall_accepts", 32'(n_acc), 32'(DEPTH));
    check("stall_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    step(mk(1'b0, SZ_WORD, 1'b0, (AW+2)'(4 * n_acc), 32'h0), acc);
    check("ready_before_pop", 32'(acc), 32'd0);
    check("ready_after_pop", 32'(req_ready), 32'd1);
    if (acc) n_acc++;
    for (idx = n_acc; idx < 8; idx++) issue(mk(1'b0, SZ_WORD, 1'b0, (AW+2)'(4 * idx), 32'h0));
    drain();

    // Reset with stage 1 and FIFO full; pending responses are discarded.
    rsp_ready = 1'b0;
    n_acc = 0;
    k = 0;
    while (n_acc < DEPTH && k < 20) begin
      step(mk(1'b0, SZ_WORD, 1'b0, (AW+2)'(4 * k), 32'h0), acc);
      if (acc) n_acc++;
      k++;
    end
    check("fill_accepts", 32'(n_acc), 32'(DEPTH));
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_ram_en", 32'(ram_en), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_ready_after_release", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    repeat (10) idle();

    // Random traffic with random response backpressure and idle gaps.
    for (int i = 0; i < 300; i++) begin
      r = rand_req();
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = 1'($urandom_range(0, 2) != 0);
        idle();
      end
      k = 0;
      do begin
        rsp_ready = 1'($urandom_range(0, 2) != 0);
        step(r, acc);
        k++;
      end while (!acc && k < 100);
      if (!acc) begin
        n_checks++; n_fail++;
        $display("FAIL random_timeout: request not accepted in %0d cycles, expected acceptance", k);
      end
    end
    rsp_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
